// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow, possibly asynchronous square wave
// in clk_in cycles, one measurement per start pulse, with a cycle-count timeout.
module clock_period_meter #(
  parameter int                   CNT_WIDTH   = 28,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT     = 28'd100000000
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 start,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = TIMEOUT - 1'b1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   sync_sig;
  logic                   rise;
  logic                   fall;
  logic                   at_limit;

  state_t                 state_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [CNT_WIDTH-1:0]   high_acc_reg;
  logic [CNT_WIDTH-1:0]   period_reg;
  logic [CNT_WIDTH-1:0]   high_time_reg;
  logic                   fall_seen_reg;
  logic                   valid_reg;
  logic                   timeout_reg;
  logic                   busy_reg;

  // Synchronizer and edge history run in every state so that edges are
  // always judged against a settled previous level.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_sig = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_sig & ~prev_reg;
  assign fall     = ~sync_sig & prev_reg;
  assign at_limit = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      high_acc_reg  <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      fall_seen_reg <= 1'b0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= WAIT_FIRST;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        WAIT_FIRST: begin
          if (rise) begin
            state_reg     <= MEASURE;
            cnt_reg       <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            high_acc_reg  <= '0;
            fall_seen_reg <= 1'b0;
          end else if (at_limit) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        MEASURE: begin
          // A rise on the last allowed count still completes the measurement.
          if (rise) begin
            period_reg    <= cnt_reg;
            high_time_reg <= high_acc_reg;
            valid_reg     <= 1'b1;
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
          end else if (at_limit) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (fall && !fall_seen_reg) begin
              high_acc_reg  <= cnt_reg;
              fall_seen_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign period    = period_reg;
  assign high_time = high_time_reg;
  assign valid     = valid_reg;
  assign busy      = busy_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: synchronous and asynchronous square
// waves, timeout, start filtering and reset during a measurement.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int CW = 28;

  logic          clk_in;
  logic          rst_n;
  logic          sig_in;
  logic          start;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          busy;
  logic          timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Waveform control: 0 = constant level, 1 = clock-synchronous, 2 = time-based.
  int   wave_mode  = 0;
  int   wave_high  = 5;
  int   wave_low   = 5;
  int   wave_gen   = 0;
  int   wave_phase = 0;
  logic wave_level = 1'b0;

  logic          got_valid;
  logic          got_timeout;
  logic          got_busy;
  logic [CW-1:0] got_period;
  logic [CW-1:0] got_high;

  clock_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(2),
    .TIMEOUT    (28'd50)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .start    (start),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    int seen_gen;
    int wave_cnt;
    seen_gen = 0;
    wave_cnt = 0;
    sig_in   = 1'b0;
    forever begin
      if (wave_mode == 2) begin
        #1;
        sig_in = ((($time + 64'(wave_phase)) % 64'd200) < 64'd100);
      end else begin
        @(posedge clk_in);
        #1;
        if (wave_gen != seen_gen) begin
          seen_gen = wave_gen;
          wave_cnt = 0;
        end
        if (wave_mode == 1) begin
          sig_in   = (wave_cnt < wave_high);
          wave_cnt = (wave_cnt + 1) % (wave_high + wave_low);
        end else begin
          sig_in = wave_level;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    got_valid   = 1'b0;
    got_timeout = 1'b0;
    got_busy    = 1'b0;
    got_period  = '0;
    got_high    = '0;
    n = 0;
    while (n < max_cycles && !got_valid && !got_timeout) begin
      @(negedge clk_in);
      n++;
      if (valid || timeout) begin
        got_valid   = valid;
        got_timeout = timeout;
        got_busy    = busy;
        got_period  = period;
        got_high    = high_time;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk_in);
    total_cnt++; if (period !== 28'd0) $display("FAIL reset_period got %0d want 0", period); else pass_cnt++;
    total_cnt++; if (high_time !== 28'd0) $display("FAIL reset_high got %0d want 0", high_time); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else pass_cnt++;
    rst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    wave_high = 5;
    wave_low  = 5;
    wave_gen++;
    wave_mode = 1;
    repeat (20) @(negedge clk_in);
    pulse_start();
    wait_done(60);
    $display("basic: valid=%b period=%0d high=%0d busy=%b", got_valid, got_period, got_high, got_busy);
    total_cnt++; if (got_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", got_valid); else pass_cnt++;
    total_cnt++; if (got_period !== 28'd10) $display("FAIL basic_period got %0d want 10", got_period); else pass_cnt++;
    total_cnt++; if (got_high !== 28'd5) $display("FAIL basic_high got %0d want 5", got_high); else pass_cnt++;
    total_cnt++; if (got_busy !== 1'b0) $display("FAIL basic_busy got %b want 0", got_busy); else pass_cnt++;
    @(negedge clk_in);
    total_cnt++; if (valid !== 1'b0) $display("FAIL basic_valid_width got %b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_asym();
    wave_high = 3;
    wave_low  = 9;
    wave_gen++;
    wave_mode = 1;
    repeat (15) @(negedge clk_in);
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      wait_done(80);
      $display("asym run %0d: valid=%b period=%0d high=%0d", r, got_valid, got_period, got_high);
      total_cnt++; if (got_valid !== 1'b1) $display("FAIL asym_valid run %0d got %b want 1", r, got_valid); else pass_cnt++;
      total_cnt++; if (got_period !== 28'd12) $display("FAIL asym_period run %0d got %0d want 12", r, got_period); else pass_cnt++;
      total_cnt++; if (got_high !== 28'd3) $display("FAIL asym_high run %0d got %0d want 3", r, got_high); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int first_to;
    int n_valid;
    int n_to;
    logic busy_k1;
    logic busy_k51;
    wave_level = 1'b0;
    wave_mode  = 0;
    repeat (6) @(negedge clk_in);
    first_to = 0;
    n_valid  = 0;
    n_to     = 0;
    busy_k1  = 1'b0;
    busy_k51 = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 53; k++) begin
      @(negedge clk_in);
      start = 1'b0;
      if (timeout) begin
        n_to++;
        if (first_to == 0) first_to = k;
      end
      if (valid) n_valid++;
      if (k == 1) busy_k1 = busy;
      if (k == 51) busy_k51 = busy;
    end
    $display("timeout: first at cycle %0d, pulses=%0d, valids=%0d", first_to, n_to, n_valid);
    total_cnt++; if (first_to != 51) $display("FAIL timeout_cycle got %0d want 51", first_to); else pass_cnt++;
    total_cnt++; if (n_to != 1) $display("FAIL timeout_pulses got %0d want 1", n_to); else pass_cnt++;
    total_cnt++; if (n_valid != 0) $display("FAIL timeout_valid got %0d want 0", n_valid); else pass_cnt++;
    total_cnt++; if (busy_k1 !== 1'b1) $display("FAIL timeout_busy_start got %b want 1", busy_k1); else pass_cnt++;
    total_cnt++; if (busy_k51 !== 1'b0) $display("FAIL timeout_busy_end got %b want 0", busy_k51); else pass_cnt++;
    total_cnt++; if (period !== 28'd12) $display("FAIL timeout_period_hold got %0d want 12", period); else pass_cnt++;
    total_cnt++; if (high_time !== 28'd3) $display("FAIL timeout_high_hold got %0d want 3", high_time); else pass_cnt++;
  endtask

  task automatic test_start_conditions();
    int n_valid;
    int n_to;
    int n;
    logic [CW-1:0] p;
    logic [CW-1:0] h;
    logic busy_extra;
    wave_high = 5;
    wave_low  = 5;
    wave_gen++;
    wave_mode = 1;
    repeat (12) @(negedge clk_in);
    n = 0;
    @(negedge clk_in);
    while (sig_in !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    total_cnt++; if (sig_in !== 1'b1) $display("FAIL startcond_sig_high got %b want 1", sig_in); else pass_cnt++;
    repeat (2) @(negedge clk_in);
    pulse_start();
    n_valid    = 0;
    n_to       = 0;
    p          = '0;
    h          = '0;
    busy_extra = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      start = (i == 2 || i == 5 || i == 8);
      if (start && !busy) busy_extra = 1'b0;
      if (valid) begin
        n_valid++;
        p = period;
        h = high_time;
      end
      if (timeout) n_to++;
    end
    start = 1'b0;
    $display("start_conditions: valids=%0d period=%0d high=%0d", n_valid, p, h);
    total_cnt++; if (busy_extra !== 1'b1) $display("FAIL startcond_busy_during_extra got %b want 1", busy_extra); else pass_cnt++;
    total_cnt++; if (n_valid != 1) $display("FAIL startcond_valid_count got %0d want 1", n_valid); else pass_cnt++;
    total_cnt++; if (n_to != 0) $display("FAIL startcond_timeout_count got %0d want 0", n_to); else pass_cnt++;
    total_cnt++; if (p !== 28'd10) $display("FAIL startcond_period got %0d want 10", p); else pass_cnt++;
    total_cnt++; if (h !== 28'd5) $display("FAIL startcond_high got %0d want 5", h); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic last_sig;
    logic seen_rise;
    int n;
    int n_pulse;
    repeat (5) @(negedge clk_in);
    pulse_start();
    last_sig  = sig_in;
    seen_rise = 1'b0;
    n = 0;
    while (!seen_rise && n < 25) begin
      @(negedge clk_in);
      n++;
      if (sig_in === 1'b1 && last_sig === 1'b0) seen_rise = 1'b1;
      last_sig = sig_in;
    end
    total_cnt++; if (seen_rise !== 1'b1) $display("FAIL resetmid_rise_seen got %b want 1", seen_rise); else pass_cnt++;
    repeat (4) @(negedge clk_in);
    total_cnt++; if (busy !== 1'b1) $display("FAIL resetmid_busy_before got %b want 1", busy); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL resetmid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (period !== 28'd0) $display("FAIL resetmid_period got %0d want 0", period); else pass_cnt++;
    total_cnt++; if (high_time !== 28'd0) $display("FAIL resetmid_high got %0d want 0", high_time); else pass_cnt++;
    n_pulse = 0;
    if (valid || timeout) n_pulse++;
    repeat (4) begin
      @(negedge clk_in);
      if (valid || timeout) n_pulse++;
    end
    total_cnt++; if (n_pulse != 0) $display("FAIL resetmid_pulses got %0d want 0", n_pulse); else pass_cnt++;
    pulse_start();
    wait_done(60);
    $display("reset_mid re-measure: valid=%b period=%0d high=%0d", got_valid, got_period, got_high);
    total_cnt++; if (got_valid !== 1'b1) $display("FAIL resetmid_remeasure_valid got %b want 1", got_valid); else pass_cnt++;
    total_cnt++; if (got_period !== 28'd10) $display("FAIL resetmid_remeasure_period got %0d want 10", got_period); else pass_cnt++;
    total_cnt++; if (got_high !== 28'd5) $display("FAIL resetmid_remeasure_high got %0d want 5", got_high); else pass_cnt++;
  endtask

  task automatic test_async();
    for (int r = 0; r < 103; r++) begin
      if (r < 100) begin
        wave_phase = int'($urandom_range(0, 199));
        if (wave_phase % 10 == 5) wave_phase = wave_phase + 1;
      end else begin
        wave_phase = 37;
      end
      wave_mode = 2;
      repeat (25) @(negedge clk_in);
      pulse_start();
      wait_done(80);
      $display("async run %0d phase=%0d: valid=%b period=%0d high=%0d", r, wave_phase, got_valid, got_period, got_high);
      total_cnt++; if (got_valid !== 1'b1) $display("FAIL async_valid run %0d got %b want 1", r, got_valid); else pass_cnt++;
      if (r < 100) begin
        total_cnt++;
        if (got_period < 28'd19 || got_period > 28'd21) $display("FAIL async_period run %0d got %0d want 19..21", r, got_period);
        else pass_cnt++;
        total_cnt++;
        if (got_high < 28'd9 || got_high > 28'd11) $display("FAIL async_high run %0d got %0d want 9..11", r, got_high);
        else pass_cnt++;
      end else begin
        total_cnt++; if (got_period !== 28'd20) $display("FAIL async_fixed_period run %0d got %0d want 20", r, got_period); else pass_cnt++;
        total_cnt++; if (got_high !== 28'd10) $display("FAIL async_fixed_high run %0d got %0d want 10", r, got_high); else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_basic();
    test_asym();
    test_timeout();
    test_start_conditions();
    test_reset_mid();
    test_async();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
